// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: load-use bubble/stall, EX backpressure hold, branch flush.
// Optional ID_EX_PERF_CNT_EN adds saturating bubble/hold performance counters.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [1:0]        id_ALUOp,
    input  logic              id_branch,
    input  logic              id_mem_to_regs,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_alusrc,
    input  logic              id_regs_write,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7_5,
    input  logic              ex_ready,
    input  logic              ex_flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [1:0]        ex_ALUOp,
    output logic              ex_branch,
    output logic              ex_mem_to_regs,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_alusrc,
    output logic              ex_regs_write,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [2:0]        ex_funct3,
    output logic              ex_funct7_5,
    output logic [31:0]       perf_bubble_cnt,
    output logic [31:0]       perf_hold_cnt
);

    typedef struct packed {
        logic [1:0] alu_op;
        logic       branch;
        logic       mem_to_regs;
        logic       mem_read;
        logic       mem_write;
        logic       alusrc;
        logic       regs_write;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic              funct7_5;
    } data_t;

    ctrl_t id_ctrl, ctrl_q, ctrl_d;
    data_t id_data, data_q, data_d;
    logic  valid_q, valid_d;
    logic  hold, hazard;

    assign id_ctrl = '{id_ALUOp, id_branch, id_mem_to_regs, id_mem_read,
                       id_mem_write, id_alusrc, id_regs_write};
    assign id_data = '{id_pc, id_rs1_data, id_rs2_data, id_imm,
                       id_rs1, id_rs2, id_rd, id_funct3, id_funct7_5};

    assign hold   = valid_q & ~ex_ready;
    assign hazard = valid_q & ctrl_q.mem_read & (data_q.rd != '0) & id_valid &
                    ((id_rs1_used & (id_rs1 == data_q.rd)) |
                     (id_rs2_used & (id_rs2 == data_q.rd)));

    assign id_stall = ~rst & ~ex_flush & (hold | hazard);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (ex_flush || (!hold && hazard)) begin
            // Bubble: kill control only; data fields are don't-care once valid drops.
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (!hold) begin
            valid_d = id_valid;
            ctrl_d  = id_valid ? id_ctrl : '0;
            data_d  = id_data;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign ex_valid       = valid_q;
    assign ex_ALUOp       = ctrl_q.alu_op;
    assign ex_branch      = ctrl_q.branch;
    assign ex_mem_to_regs = ctrl_q.mem_to_regs;
    assign ex_mem_read    = ctrl_q.mem_read;
    assign ex_mem_write   = ctrl_q.mem_write;
    assign ex_alusrc      = ctrl_q.alusrc;
    assign ex_regs_write  = ctrl_q.regs_write;
    assign ex_pc          = data_q.pc;
    assign ex_rs1_data    = data_q.rs1_data;
    assign ex_rs2_data    = data_q.rs2_data;
    assign ex_imm         = data_q.imm;
    assign ex_rs1         = data_q.rs1;
    assign ex_rs2         = data_q.rs2;
    assign ex_rd          = data_q.rd;
    assign ex_funct3      = data_q.funct3;
    assign ex_funct7_5    = data_q.funct7_5;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, hold_cnt_q;

    // Flush edges are excluded from both counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            if (!ex_flush && !hold && hazard && bubble_cnt_q != '1)
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (!ex_flush && hold && hold_cnt_q != '1)
                hold_cnt_q <= hold_cnt_q + 32'd1;
        end
    end

    assign perf_bubble_cnt = bubble_cnt_q;
    assign perf_hold_cnt   = hold_cnt_q;
`else
    assign perf_bubble_cnt = 32'h0;
    assign perf_hold_cnt   = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed pipeline scenarios then random traffic vs an
// instruction-level reference model (counter checks follow ID_EX_PERF_CNT_EN).
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, id_valid, id_branch, id_mem_to_regs, id_mem_read, id_mem_write;
    logic        id_alusrc, id_regs_write, id_rs1_used, id_rs2_used, id_funct7_5;
    logic        ex_ready, ex_flush;
    logic [1:0]  id_ALUOp;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic        id_stall, ex_valid, ex_branch, ex_mem_to_regs, ex_mem_read, ex_mem_write;
    logic        ex_alusrc, ex_regs_write, ex_funct7_5;
    logic [1:0]  ex_ALUOp;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, perf_bubble_cnt, perf_hold_cnt;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ALUOp(id_ALUOp), .id_branch(id_branch),
        .id_mem_to_regs(id_mem_to_regs), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_alusrc(id_alusrc), .id_regs_write(id_regs_write), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
        .ex_ready(ex_ready), .ex_flush(ex_flush), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_ALUOp(ex_ALUOp), .ex_branch(ex_branch), .ex_mem_to_regs(ex_mem_to_regs),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_alusrc(ex_alusrc),
        .ex_regs_write(ex_regs_write), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5),
        .perf_bubble_cnt(perf_bubble_cnt), .perf_hold_cnt(perf_hold_cnt)
    );

    // Control byte layout: {ALUOp[1:0], branch, mem_to_regs, mem_read, mem_write, alusrc, regs_write}
    localparam logic [7:0] C_ALU  = 8'b10_0_0_0_0_0_1;
    localparam logic [7:0] C_ALUI = 8'b10_0_0_0_0_1_1;
    localparam logic [7:0] C_LW   = 8'b00_0_1_1_0_1_1;
    localparam logic [7:0] C_SW   = 8'b00_0_0_0_1_1_0;

    // Reference model: the instruction currently sitting in EX, plus event counters.
    typedef struct {
        logic        valid;
        logic [7:0]  ctrl;
        logic [31:0] pc, r1d, r2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
    } ex_slot_t;

    ex_slot_t    m;
    logic [31:0] m_bub, m_hld;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] id_ctrl_byte();
        return {id_ALUOp, id_branch, id_mem_to_regs, id_mem_read, id_mem_write, id_alusrc, id_regs_write};
    endfunction

    // Does the ID instruction need a register the EX load has not produced yet?
    function automatic logic load_use();
        logic reads_rd;
        reads_rd = (id_rs1_used && id_rs1 == m.rd) || (id_rs2_used && id_rs2 == m.rd);
        return m.valid && m.ctrl[3] && (m.rd != 5'd0) && id_valid && reads_rd;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic id_instr(input logic v, input logic [7:0] c, input logic [31:0] pc,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input logic u1, input logic u2);
        id_valid = v;
        {id_ALUOp, id_branch, id_mem_to_regs, id_mem_read, id_mem_write, id_alusrc, id_regs_write} = c;
        id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_used = u1; id_rs2_used = u2;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_funct3 = 3'($urandom); id_funct7_5 = 1'($urandom);
    endtask

    // One clock: check the combinational stall, advance the model, check registered outputs.
    task automatic step();
        logic stalled_by_ex, hz, exp_stall;
        logic [31:0] exp_b, exp_h;
        #1;
        stalled_by_ex = m.valid && !ex_ready;
        hz            = load_use();
        exp_stall     = !rst && !ex_flush && (stalled_by_ex || hz);
        check("id_stall", {31'd0, id_stall}, {31'd0, exp_stall});
        @(posedge clk);
        if (rst) begin
            m = '{valid: 1'b0, ctrl: 8'd0, pc: 0, r1d: 0, r2d: 0, imm: 0, rs1: 0, rs2: 0, rd: 0, f3: 0, f7: 1'b0};
            m_bub = 0; m_hld = 0;
        end else if (ex_flush) begin
            m.valid = 1'b0; m.ctrl = 8'd0;
        end else if (stalled_by_ex) begin
            m_hld = sat_inc(m_hld);
        end else if (hz) begin
            m.valid = 1'b0; m.ctrl = 8'd0;
            m_bub = sat_inc(m_bub);
        end else begin
            m.valid = id_valid;
            m.ctrl  = id_valid ? id_ctrl_byte() : 8'd0;
            m.pc = id_pc; m.r1d = id_rs1_data; m.r2d = id_rs2_data; m.imm = id_imm;
            m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd; m.f3 = id_funct3; m.f7 = id_funct7_5;
        end
        #1;
`ifdef ID_EX_PERF_CNT_EN
        exp_b = m_bub; exp_h = m_hld;
`else
        exp_b = 32'd0; exp_h = 32'd0;
`endif
        check("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
        check("ex_ctrl", {24'd0, ex_ALUOp, ex_branch, ex_mem_to_regs, ex_mem_read, ex_mem_write,
                          ex_alusrc, ex_regs_write}, {24'd0, m.ctrl});
        check("ex_pc", ex_pc, m.pc);
        check("ex_rs1_data", ex_rs1_data, m.r1d);
        check("ex_rs2_data", ex_rs2_data, m.r2d);
        check("ex_imm", ex_imm, m.imm);
        check("ex_regs", {13'd0, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7_5},
                         {13'd0, m.rs1, m.rs2, m.rd, m.f3, m.f7});
        check("perf_bubble_cnt", perf_bubble_cnt, exp_b);
        check("perf_hold_cnt", perf_hold_cnt, exp_h);
    endtask

    initial begin
        m = '{valid: 1'b0, ctrl: 8'd0, pc: 0, r1d: 0, r2d: 0, imm: 0, rs1: 0, rs2: 0, rd: 0, f3: 0, f7: 1'b0};
        m_bub = 0; m_hld = 0;
        rst = 1'b1; ex_ready = 1'b1; ex_flush = 1'b0;
        id_instr(1'b1, C_LW, 32'h40, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        step();
        step();
        check("reset_valid", {31'd0, ex_valid}, 32'd0);
        rst = 1'b0;

        // Back-to-back ALU ops
        id_instr(1'b1, C_ALUI, 32'h0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0); step();
        check("b2b_pc0", ex_pc, 32'h0);
        id_instr(1'b1, C_ALUI, 32'h4, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0); step();
        check("b2b_pc4", ex_pc, 32'h4);
        check("b2b_valid", {31'd0, ex_valid}, 32'd1);

        // lw x5 ; add x6,x5,x7 -> one bubble then capture
        id_instr(1'b1, C_LW, 32'h8, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0); step();
        id_instr(1'b1, C_ALU, 32'hC, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1);
        #1 check("lu_stall", {31'd0, id_stall}, 32'd1);
        step();
        check("lu_bubble", {31'd0, ex_valid}, 32'd0);
        step();
        check("lu_capture_rs1", {27'd0, ex_rs1}, 32'd5);

        // lw x0 ; add x6,x0,x7 and lw x5 ; addi x6,x0,1 (rs2 = 5 unused) -> no stall
        id_instr(1'b1, C_LW, 32'h10, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); step();
        id_instr(1'b1, C_ALU, 32'h14, 5'd0, 5'd7, 5'd6, 1'b1, 1'b1); step();
        id_instr(1'b1, C_LW, 32'h18, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0); step();
        id_instr(1'b1, C_ALUI, 32'h1C, 5'd0, 5'd5, 5'd6, 1'b1, 1'b0); step();
        check("rs2_unused_pc", ex_pc, 32'h1C);

        // Three cycles of backpressure, then release
        ex_ready = 1'b0;
        id_instr(1'b1, C_ALU, 32'h20, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step();
        check("hold_pc_stable", ex_pc, 32'h1C);
        ex_ready = 1'b1; step();
        check("hold_release_pc", ex_pc, 32'h20);

        // Flush beats simultaneous hold and hazard
        id_instr(1'b1, C_LW, 32'h24, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0); step();
        ex_ready = 1'b0; ex_flush = 1'b1;
        id_instr(1'b1, C_SW, 32'h28, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1); step();
        check("flush_mem_write", {31'd0, ex_mem_write}, 32'd0);
        ex_flush = 1'b0; ex_ready = 1'b1;

        // Reset pulse during hold, then an invalid slot carrying regs_write
        id_instr(1'b1, C_ALU, 32'h30, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1); step();
        ex_ready = 1'b0; step();
        rst = 1'b1; step();
        rst = 1'b0; ex_ready = 1'b1;
        id_instr(1'b0, C_ALU, 32'h34, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1); step();
        check("invalid_no_rw", {31'd0, ex_regs_write}, 32'd0);

        // Random traffic with small register indices to provoke hazards
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 99) < 2);
            ex_flush = ($urandom_range(0, 99) < 8);
            ex_ready = ($urandom_range(0, 99) < 70);
            id_instr(($urandom_range(0, 99) < 85), 8'($urandom), $urandom,
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) id_mem_read = 1'b1;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
